// File: rtl/onehot_fsm_engine.sv
// onehot_fsm_engine: table-driven one-hot Mealy FSM with registered output and runtime-loadable table
module onehot_fsm_engine #(
  parameter int NUM_STATES = 3,
  parameter int NUM_EVENTS = 2,
  parameter int OUT_W = 2,
  parameter int RST_STATE = 2,
  localparam int SW = NUM_STATES > 1 ? $clog2(NUM_STATES) : 1,
  localparam int EW = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] ev,
  input  logic                  cfg_we,
  input  logic [SW-1:0]         cfg_state,
  input  logic [EW-1:0]         cfg_event,
  input  logic                  cfg_en,
  input  logic [SW-1:0]         cfg_next,
  input  logic [OUT_W-1:0]      cfg_out,
  output logic [NUM_STATES-1:0] state,
  output logic [OUT_W-1:0]      out,
  output logic                  fire,
  output logic                  cfg_err,
  output logic                  state_err
);
  localparam logic [NUM_STATES-1:0] RST_OH = NUM_STATES'(1) << RST_STATE;
  logic                  en_t  [NUM_STATES][NUM_EVENTS];
  logic [SW-1:0]         nx_t  [NUM_STATES][NUM_EVENTS];
  logic [OUT_W-1:0]      out_t [NUM_STATES][NUM_EVENTS];
  logic [SW-1:0]         cur;
  logic [EW-1:0]         w;
  logic                  hit, legal, cfg_ok;
  logic [NUM_STATES-1:0] nxt_state;
  logic [OUT_W-1:0]      nxt_out;
  // decode current state, pick highest-index enabled event, compute next register values
  always_comb begin
    cur = '0;
    for (int s = 0; s < NUM_STATES; s++) cur = state[s] ? SW'(s) : cur;
    hit = 1'b0;
    w = '0;
    for (int e = 0; e < NUM_EVENTS; e++) if (ev[e] && en_t[cur][e]) begin
      hit = 1'b1;
      w = EW'(e);
    end
    legal = $onehot(state);
    nxt_state = !legal ? RST_OH : hit ? NUM_STATES'(1) << nx_t[cur][w] : state;
    nxt_out = legal && hit ? out_t[cur][w] : out;
    cfg_ok = int'(cfg_state) < NUM_STATES && int'(cfg_event) < NUM_EVENTS && int'(cfg_next) < NUM_STATES;
  end
  // state, output and pulse flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_OH;
      out <= '0;
      fire <= 1'b0;
      cfg_err <= 1'b0;
      state_err <= 1'b0;
    end else begin
      state <= nxt_state;
      out <= nxt_out;
      fire <= legal && hit;
      cfg_err <= cfg_we && !cfg_ok;
      state_err <= !legal;
    end
  end
  // transition table; only enables are cleared on reset, the rest is don't-care until written
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STATES; s++)
        for (int e = 0; e < NUM_EVENTS; e++) en_t[s][e] <= 1'b0;
    end else if (cfg_we && cfg_ok) begin
      en_t[cfg_state][cfg_event] <= cfg_en;
      nx_t[cfg_state][cfg_event] <= cfg_next;
      out_t[cfg_state][cfg_event] <= cfg_out;
    end
  end
endmodule

// File: tb/tb_onehot_fsm_engine.sv
// tb_onehot_fsm_engine: directed checks of the one-hot table FSM at default and wide configurations
module tb_onehot_fsm_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic       rst, cfg_we, cfg_en;
  logic [1:0] ev, cfg_state, cfg_next, cfg_out, out;
  logic [0:0] cfg_event;
  logic [2:0] state;
  logic       fire, cfg_err, state_err;
  logic       rst_b, cfg_we_b, cfg_en_b;
  logic [3:0] ev_b, cfg_out_b, out_b;
  logic [2:0] cfg_state_b, cfg_next_b;
  logic [1:0] cfg_event_b;
  logic [4:0] state_b;
  logic       fire_b, cfg_err_b, state_err_b;
  onehot_fsm_engine dut_a (
    .clk(clk), .rst(rst), .ev(ev), .cfg_we(cfg_we), .cfg_state(cfg_state), .cfg_event(cfg_event),
    .cfg_en(cfg_en), .cfg_next(cfg_next), .cfg_out(cfg_out), .state(state), .out(out),
    .fire(fire), .cfg_err(cfg_err), .state_err(state_err)
  );
  onehot_fsm_engine #(.NUM_STATES(5), .NUM_EVENTS(4), .OUT_W(4), .RST_STATE(2)) dut_b (
    .clk(clk), .rst(rst_b), .ev(ev_b), .cfg_we(cfg_we_b), .cfg_state(cfg_state_b), .cfg_event(cfg_event_b),
    .cfg_en(cfg_en_b), .cfg_next(cfg_next_b), .cfg_out(cfg_out_b), .state(state_b), .out(out_b),
    .fire(fire_b), .cfg_err(cfg_err_b), .state_err(state_err_b)
  );
  task automatic cfg_a(input logic [1:0] s, input logic e, input logic en, input logic [1:0] nx, input logic [1:0] o);
    cfg_we = 1'b1;
    cfg_state = s;
    cfg_event = e;
    cfg_en = en;
    cfg_next = nx;
    cfg_out = o;
  endtask
  task automatic cfg_b(input logic [2:0] s, input logic [1:0] e, input logic [2:0] nx, input logic [3:0] o);
    cfg_we_b = 1'b1;
    cfg_state_b = s;
    cfg_event_b = e;
    cfg_en_b = 1'b1;
    cfg_next_b = nx;
    cfg_out_b = o;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rst_b = 1'b0;
    n_cmp++; if (state !== 3'b100) begin n_err++; $display("FAIL reset_state: got %b want 100", state); end
    n_cmp++; if (out !== 2'b00) begin n_err++; $display("FAIL reset_out: got %b want 00", out); end
    n_cmp++; if ({fire, cfg_err, state_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {fire, cfg_err, state_err}); end
    n_cmp++; if (state_b !== 5'b00100) begin n_err++; $display("FAIL reset_state_b: got %b want 00100", state_b); end
    ev = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if ({state, out, fire} !== 6'b100_00_0) begin n_err++; $display("FAIL empty_table cyc%0d: got %b want 100000", i, {state, out, fire}); end
    end
    ev = 2'b00;
  endtask
  task automatic test_priority;
    cfg_a(2'd2, 1'b0, 1'b1, 2'd1, 2'b10);
    @(negedge clk);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL good_write_err: got %b want 0", cfg_err); end
    cfg_a(2'd2, 1'b1, 1'b1, 2'd0, 2'b01);
    @(negedge clk);
    cfg_we = 1'b0;
    ev = 2'b11;
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b001_01_1) begin n_err++; $display("FAIL priority: got %b want 001011", {state, out, fire}); end
    ev = 2'b00;
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b001_01_0) begin n_err++; $display("FAIL hold: got %b want 001010", {state, out, fire}); end
  endtask
  task automatic test_write_during_use;
    cfg_a(2'd0, 1'b0, 1'b1, 2'd1, 2'b00);
    @(negedge clk);
    cfg_a(2'd1, 1'b0, 1'b1, 2'd1, 2'b01);
    @(negedge clk);
    cfg_we = 1'b0;
    ev = 2'b01;
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b010_00_1) begin n_err++; $display("FAIL to_state1: got %b want 010001", {state, out, fire}); end
    cfg_a(2'd1, 1'b0, 1'b1, 2'd2, 2'b11);
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b010_01_1) begin n_err++; $display("FAIL old_entry_selfloop: got %b want 010011", {state, out, fire}); end
    cfg_we = 1'b0;
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b100_11_1) begin n_err++; $display("FAIL new_entry: got %b want 100111", {state, out, fire}); end
    ev = 2'b00;
  endtask
  task automatic test_cfg_err;
    cfg_a(2'd3, 1'b0, 1'b1, 2'd0, 2'b00);
    @(negedge clk);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_state: got %b want 1", cfg_err); end
    cfg_a(2'd2, 1'b0, 1'b1, 2'd3, 2'b11);
    @(negedge clk);
    n_cmp++; if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_next: got %b want 1", cfg_err); end
    cfg_we = 1'b0;
    @(negedge clk);
    n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_clear: got %b want 0", cfg_err); end
    ev = 2'b01;
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b010_10_1) begin n_err++; $display("FAIL table_unchanged: got %b want 010101", {state, out, fire}); end
    ev = 2'b00;
  endtask
  task automatic test_illegal_state;
    ev = 2'b11;
    force dut_a.state = 3'b110;
    @(negedge clk);
    release dut_a.state;
    ev = 2'b00;
    n_cmp++; if ({state_err, fire, out} !== 4'b1_0_10) begin n_err++; $display("FAIL recover: got %b want 1010", {state_err, fire, out}); end
    repeat (2) @(negedge clk);
    n_cmp++; if ({state, out, state_err} !== 6'b100_10_0) begin n_err++; $display("FAIL after_recover: got %b want 100100", {state, out, state_err}); end
  endtask
  task automatic test_mid_reset_a;
    cfg_a(2'd2, 1'b1, 1'b1, 2'd1, 2'b11);
    ev = 2'b11;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cfg_we = 1'b0;
    n_cmp++; if ({state, out, fire} !== 6'b100_00_0) begin n_err++; $display("FAIL mid_reset: got %b want 100000", {state, out, fire}); end
    @(negedge clk);
    n_cmp++; if ({state, out, fire} !== 6'b100_00_0) begin n_err++; $display("FAIL table_cleared: got %b want 100000", {state, out, fire}); end
    ev = 2'b00;
  endtask
  task automatic test_wide;
    cfg_b(3'd2, 2'd1, 3'd3, 4'b0101);
    @(negedge clk);
    cfg_b(3'd2, 2'd3, 3'd4, 4'b1010);
    @(negedge clk);
    cfg_b(3'd4, 2'd0, 3'd1, 4'b0011);
    @(negedge clk);
    cfg_b(3'd4, 2'd2, 3'd0, 4'b0110);
    @(negedge clk);
    cfg_we_b = 1'b0;
    ev_b = 4'b1010;
    @(negedge clk);
    n_cmp++; if ({state_b, out_b, fire_b} !== 10'b10000_1010_1) begin n_err++; $display("FAIL wide_ev3: got %b want 1000010101", {state_b, out_b, fire_b}); end
    ev_b = 4'b0101;
    @(negedge clk);
    n_cmp++; if ({state_b, out_b, fire_b} !== 10'b00001_0110_1) begin n_err++; $display("FAIL wide_ev2: got %b want 0000101101", {state_b, out_b, fire_b}); end
    ev_b = 4'b1111;
    cfg_b(3'd0, 2'd0, 3'd1, 4'b1111);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    cfg_we_b = 1'b0;
    n_cmp++; if ({state_b, out_b, fire_b} !== 10'b00100_0000_0) begin n_err++; $display("FAIL wide_reset: got %b want 0010000000", {state_b, out_b, fire_b}); end
    ev_b = 4'b1010;
    @(negedge clk);
    n_cmp++; if ({state_b, out_b, fire_b} !== 10'b00100_0000_0) begin n_err++; $display("FAIL wide_cleared: got %b want 0010000000", {state_b, out_b, fire_b}); end
    ev_b = 4'b0000;
  endtask
  initial begin
    {rst, cfg_we, cfg_en, ev, cfg_state, cfg_next, cfg_out, cfg_event} = '0;
    {rst_b, cfg_we_b, cfg_en_b, ev_b, cfg_out_b, cfg_state_b, cfg_next_b, cfg_event_b} = '0;
    @(negedge clk);
    test_reset;
    test_priority;
    test_write_during_use;
    test_cfg_err;
    test_illegal_state;
    test_mid_reset_a;
    test_wide;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
